picture_blitter: RTL and testbench

- Parametrised successor to the full-screen picture selector between game logic and the VGA adapter write port.
- On request, streams one of NUM_PIC stored pictures (init/win/lose/...) into the framebuffer exactly once, or repeatedly in loop mode.
- Reads picture ROMs through an external address/data port with configurable read latency; keeps x/y/colour aligned with ROM data.
- When idle, passes game-logic pixel writes through; while a blit runs, the blit owns the write port.

---
 rtl/picture_blitter.sv | 180 ++++++++++++++++++
 tb/tb_picture_blitter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/picture_blitter.sv
// picture_blitter: streams a stored full-screen picture from an external ROM port into
// the VGA adapter write port, once or in a loop; passes game-logic writes through when idle.
module picture_blitter #(
    parameter int unsigned H_RES    = 160,
    parameter int unsigned V_RES    = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned NUM_PIC  = 3,
    parameter int unsigned PIC_W    = 2,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned ROM_LAT  = 1
) (
    input  logic                clk50M,
    input  logic                rst,
    input  logic                start,
    input  logic [PIC_W-1:0]    pic_sel,
    input  logic                loop_en,
    input  logic                stop,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                writeEn_in,
    output logic [PIC_W-1:0]    rom_pic,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                writeEn_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    // Refuse to elaborate with parameters that would truncate counters or the pipeline.
    if ((H_RES > (2 ** X_W)) || (V_RES > (2 ** Y_W)) || ((H_RES * V_RES) > (2 ** ADDR_W)) ||
        (NUM_PIC > (2 ** PIC_W)) || (ROM_LAT < 1) || (ROM_LAT > 4)) begin : g_bad_params
        $error("picture_blitter: inconsistent parameters");
    end

    localparam logic [X_W-1:0] X_LAST     = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_RES - 1);
    // Drain covers the ROM_LAT pipeline stages plus the registered output stage.
    localparam logic [2:0]     DRAIN_LAST = 3'(ROM_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } state_t;

    state_t             state;
    logic               loop_q;
    logic [X_W-1:0]     x_cnt;
    logic [Y_W-1:0]     y_cnt;
    logic [2:0]         drain_cnt;
    logic               pic_ok;

    logic [X_W-1:0]     pipe_x [ROM_LAT];
    logic [Y_W-1:0]     pipe_y [ROM_LAT];
    logic [ROM_LAT-1:0] pipe_v;

    logic [X_W-1:0]     blit_x;
    logic [Y_W-1:0]     blit_y;
    logic [COLOUR_W-1:0] blit_c;
    logic               blit_we;

    assign pic_ok = (32'(pic_sel) < NUM_PIC);
    assign busy   = (state != StIdle);

    // Control FSM: request acceptance, raster address generation, drain and status pulses.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            state     <= StIdle;
            loop_q    <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            rom_addr  <= '0;
            rom_pic   <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (pic_ok) begin
                            state    <= StFetch;
                            rom_pic  <= pic_sel;
                            loop_q   <= loop_en;
                            rom_addr <= '0;
                            x_cnt    <= '0;
                            y_cnt    <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (stop) begin
                        state     <= StDrain;
                        drain_cnt <= '0;
                    end else if (x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        if (y_cnt == Y_LAST) begin
                            if (loop_q) begin
                                y_cnt    <= '0;
                                rom_addr <= '0;
                            end else begin
                                state     <= StDrain;
                                drain_cnt <= '0;
                            end
                        end else begin
                            y_cnt    <= y_cnt + 1'b1;
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end else begin
                        x_cnt    <= x_cnt + 1'b1;
                        rom_addr <= rom_addr + 1'b1;
                    end
                end
                StDrain: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Coordinate pipeline matching ROM latency, then a registered write stage.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
            end
            pipe_v  <= '0;
            blit_x  <= '0;
            blit_y  <= '0;
            blit_c  <= '0;
            blit_we <= 1'b0;
        end else begin
            pipe_x[0] <= x_cnt;
            pipe_y[0] <= y_cnt;
            pipe_v[0] <= (state == StFetch);
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                pipe_x[i] <= pipe_x[i-1];
                pipe_y[i] <= pipe_y[i-1];
                pipe_v[i] <= pipe_v[i-1];
            end
            blit_x  <= pipe_x[ROM_LAT-1];
            blit_y  <= pipe_y[ROM_LAT-1];
            blit_c  <= rom_data;
            blit_we <= pipe_v[ROM_LAT-1];
        end
    end

    // Write-port mux: the blit owns the port while busy; game writes are dropped then.
    always_comb begin
        x_out       = x_in;
        y_out       = y_in;
        colour_out  = colour_in;
        writeEn_out = writeEn_in;
        if (busy) begin
            x_out       = blit_x;
            y_out       = blit_y;
            colour_out  = blit_c;
            writeEn_out = blit_we;
        end
    end

endmodule

// File: tb/tb_picture_blitter.sv
// Scoreboard bench: two blitters (ROM_LAT=1 and ROM_LAT=3) on shared stimulus, each with its
// own ROM model returning addr[2:0] and its own expected-write queue.
module tb_picture_blitter;

    logic       clk50M = 1'b0;
    always #5 clk50M = ~clk50M;

    logic       rst, start, loop_en, stop, writeEn_in;
    logic [1:0] pic_sel;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;

    logic [1:0]  rom_pic_a, rom_pic_b;
    logic [14:0] rom_addr_a, rom_addr_b;
    logic [2:0]  rom_data_a, rom_data_b, rb1, rb2;
    logic [7:0]  x_out_a, x_out_b;
    logic [6:0]  y_out_a, y_out_b;
    logic [2:0]  colour_out_a, colour_out_b;
    logic        writeEn_out_a, writeEn_out_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

    picture_blitter #(.H_RES(4), .V_RES(3), .ROM_LAT(1)) u_dut_a (
        .clk50M(clk50M), .rst(rst), .start(start), .pic_sel(pic_sel), .loop_en(loop_en),
        .stop(stop), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .writeEn_in(writeEn_in),
        .rom_pic(rom_pic_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a), .x_out(x_out_a),
        .y_out(y_out_a), .colour_out(colour_out_a), .writeEn_out(writeEn_out_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    picture_blitter #(.H_RES(4), .V_RES(3), .ROM_LAT(3)) u_dut_b (
        .clk50M(clk50M), .rst(rst), .start(start), .pic_sel(pic_sel), .loop_en(loop_en),
        .stop(stop), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .writeEn_in(writeEn_in),
        .rom_pic(rom_pic_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .x_out(x_out_b),
        .y_out(y_out_b), .colour_out(colour_out_b), .writeEn_out(writeEn_out_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    // ROM models: one and three clocks of read latency.
    always @(posedge clk50M) begin
        rom_data_a <= rom_addr_a[2:0];
        rb1        <= rom_addr_b[2:0];
        rb2        <= rb1;
        rom_data_b <= rb2;
    end

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_a[$];
    pix_t exp_b[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    bit   first_a, first_b;
    bit   mon_en = 1'b0;
    int   done_a_cnt = 0;
    int   done_b_cnt = 0;

    always @(posedge clk50M) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? exp_a.size() : exp_b.size();
    endfunction

    // Expected raster sequence for a 4x3 frame, repeating for loop mode; colour = addr[2:0].
    task automatic push_frame(input int n_pix);
        pix_t p;
        for (int i = 0; i < n_pix; i++) begin
            p.x = 8'((i % 12) % 4);
            p.y = 7'((i % 12) / 4);
            p.c = 3'((i % 12) % 8);
            exp_a.push_back(p);
            exp_b.push_back(p);
        end
    endtask

    task automatic mon(input int k, input int lat, input logic we, input logic bsy,
                       input logic dn, input logic [7:0] xo, input logic [6:0] yo,
                       input logic [2:0] co);
        pix_t e;
        if (mon_en && bsy && we) begin
            check($sformatf("write_expected[%0d]", k), 32'(qsize(k) > 0), 1);
            if (qsize(k) > 0) begin
                e = (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
                check($sformatf("x_out[%0d]", k), xo, e.x);
                check($sformatf("y_out[%0d]", k), yo, e.y);
                check($sformatf("colour_out[%0d]", k), co, e.c);
                if ((k == 0) ? first_a : first_b) begin
                    check($sformatf("first_write_latency[%0d]", k), cyc - start_cyc, lat + 1);
                    if (k == 0) first_a = 1'b0;
                    else first_b = 1'b0;
                end
            end
        end
        if (dn) begin
            if (k == 0) done_a_cnt++;
            else done_b_cnt++;
            if (mon_en) check($sformatf("done_after_last[%0d]", k), qsize(k), 0);
        end
    endtask

    always @(negedge clk50M) begin
        mon(0, 1, writeEn_out_a, busy_a, done_a, x_out_a, y_out_a, colour_out_a);
        mon(1, 3, writeEn_out_b, busy_b, done_b, x_out_b, y_out_b, colour_out_b);
    end

    task automatic do_start(input logic [1:0] p, input logic le);
        @(posedge clk50M); #1;
        start   = 1'b1;
        pic_sel = p;
        loop_en = le;
        @(posedge clk50M); #1;
        start     = 1'b0;
        start_cyc = cyc;
        first_a   = 1'b1;
        first_b   = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy_a || busy_b) && (n < budget)) begin
            @(posedge clk50M); #1;
            n++;
        end
        check("idle_within_budget", 32'(busy_a || busy_b), 0);
        repeat (2) @(posedge clk50M);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pic_sel = '0; loop_en = 1'b0; stop = 1'b0;
        x_in = '0; y_in = '0; colour_in = '0; writeEn_in = 1'b1;
        repeat (3) @(posedge clk50M);
        #1;
        check("reset_busy_a", busy_a, 0);
        check("reset_busy_b", busy_b, 0);
        check("reset_done_a", done_a, 0);
        check("reset_err_a", err_a, 0);
        check("reset_rom_addr_a", rom_addr_a, 0);
        check("reset_rom_pic_b", rom_pic_b, 0);
        check("reset_passthru_we_a", writeEn_out_a, 1);
        check("reset_passthru_we_b", writeEn_out_b, 1);

        rst = 1'b0; writeEn_in = 1'b0;
        @(posedge clk50M); #1;
        x_in = 8'd17; y_in = 7'd9; colour_in = 3'd5; writeEn_in = 1'b1;
        #1;
        check("pass_x_a", x_out_a, 17);
        check("pass_y_a", y_out_a, 9);
        check("pass_colour_a", colour_out_a, 5);
        check("pass_we_a", writeEn_out_a, 1);
        check("pass_x_b", x_out_b, 17);
        check("pass_we_b", writeEn_out_b, 1);
        writeEn_in = 1'b0; x_in = 8'd42;
        #1;
        check("pass_we_low_a", writeEn_out_a, 0);
        check("pass_x2_b", x_out_b, 42);

        // Single blit of picture 2 with a competing game write stream held high.
        mon_en = 1'b1;
        push_frame(12);
        x_in = 8'd200; y_in = 7'd100; colour_in = 3'd6; writeEn_in = 1'b1;
        do_start(2'd2, 1'b0);
        check("blit_rom_pic_a", rom_pic_a, 2);
        check("blit_busy_b", busy_b, 1);
        repeat (3) @(posedge clk50M);
        #1;
        start = 1'b1; pic_sel = 2'd1;
        @(posedge clk50M); #1;
        start = 1'b0;
        check("busy_start_rom_pic_a", rom_pic_a, 2);
        check("busy_start_rom_pic_b", rom_pic_b, 2);
        check("busy_start_no_err_a", err_a, 0);
        wait_idle(100);
        writeEn_in = 1'b0;
        check("blit_all_written_a", exp_a.size(), 0);
        check("blit_all_written_b", exp_b.size(), 0);
        check("blit_done_count_a", done_a_cnt, 1);
        check("blit_done_count_b", done_b_cnt, 1);

        // Out-of-range picture select is rejected.
        do_start(2'd3, 1'b0);
        check("bad_pic_err_a", err_a, 1);
        check("bad_pic_err_b", err_b, 1);
        check("bad_pic_busy_a", busy_a, 0);
        check("bad_pic_we_a", writeEn_out_a, 0);
        @(posedge clk50M); #1;
        check("bad_pic_err_pulse_a", err_a, 0);

        // Loop mode, stop on the 20th fetch cycle.
        push_frame(20);
        do_start(2'd0, 1'b1);
        repeat (19) @(posedge clk50M);
        #1;
        check("loop_addr_at_stop_a", rom_addr_a, 7);
        stop = 1'b1;
        @(posedge clk50M); #1;
        stop = 1'b0;
        wait_idle(100);
        check("loop_all_written_a", exp_a.size(), 0);
        check("loop_all_written_b", exp_b.size(), 0);
        check("loop_done_count_a", done_a_cnt, 2);
        check("loop_done_count_b", done_b_cnt, 2);

        // Reset in the middle of a blit.
        mon_en = 1'b0;
        do_start(2'd1, 1'b0);
        repeat (6) @(posedge clk50M);
        #1;
        check("mid_addr_a", rom_addr_a, 6);
        rst = 1'b1; writeEn_in = 1'b1; x_in = 8'd33;
        @(posedge clk50M); #1;
        check("mid_rst_busy_a", busy_a, 0);
        check("mid_rst_busy_b", busy_b, 0);
        check("mid_rst_we_a", writeEn_out_a, 1);
        check("mid_rst_x_b", x_out_b, 33);
        check("mid_rst_addr_b", rom_addr_b, 0);
        rst = 1'b0; writeEn_in = 1'b0;
        #1;
        check("mid_rst_we_low_b", writeEn_out_b, 0);
        repeat (6) @(posedge clk50M);
        #1;
        check("mid_rst_no_done_a", done_a_cnt, 2);
        check("mid_rst_no_done_b", done_b_cnt, 2);

        // Restart after the reset draws a clean frame from address 0.
        mon_en = 1'b1;
        push_frame(12);
        do_start(2'd0, 1'b0);
        check("restart_addr_b", rom_addr_b, 0);
        check("restart_pic_a", rom_pic_a, 0);
        wait_idle(100);
        check("restart_all_written_a", exp_a.size(), 0);
        check("restart_all_written_b", exp_b.size(), 0);
        check("restart_done_count_a", done_a_cnt, 3);
        check("restart_done_count_b", done_b_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
